// File: rtl/event_quantizer_if.sv
// Stream bundle for event_quantizer: raw event input, filter enable,
// quantized event output and pass/drop statistics.
interface event_quantizer_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int T_W   = 16,
  parameter int SHIFT = 4,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [X_W-1:0]       in_x;
  logic [Y_W-1:0]       in_y;
  logic [T_W-1:0]       in_t;
  logic                 in_pol;
  logic                 flt_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [X_W-SHIFT-1:0] out_cx;
  logic [Y_W-SHIFT-1:0] out_cy;
  logic [T_W-1:0]       out_t;
  logic                 out_pol;
  logic [CNT_W-1:0]     pass_cnt;
  logic [CNT_W-1:0]     drop_cnt;

  // Quantizer side
  modport slave (
    input  in_valid, in_x, in_y, in_t, in_pol, flt_en, out_ready,
    output in_ready, out_valid, out_cx, out_cy, out_t, out_pol, pass_cnt, drop_cnt
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_x, in_y, in_t, in_pol, flt_en, out_ready,
    input  in_ready, out_valid, out_cx, out_cy, out_t, out_pol, pass_cnt, drop_cnt
  );
endinterface

// File: rtl/event_quantizer.sv
// event_quantizer: two-stage pipeline that quantizes sensor events to grid
// cells and suppresses refractory duplicates (same cell and polarity as the
// last passed event, within REFRACT ticks, modulo timestamp wrap).
// S1 holds the captured event, S2 drives the output. Full backpressure,
// one event per cycle, saturating pass/drop counters.
module event_quantizer #(
  parameter int          X_W     = 8,
  parameter int          Y_W     = 8,
  parameter int          T_W     = 16,
  parameter int          SHIFT   = 4,
  parameter int unsigned REFRACT = 100,
  parameter int          CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  event_quantizer_if.slave bus
);
  localparam int CX_W = X_W - SHIFT;
  localparam int CY_W = Y_W - SHIFT;
  localparam logic [T_W-1:0] REFRACT_T = T_W'(REFRACT);

  // Saturating increment for the statistics counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // S1 registers
  logic            s1_valid_r;
  logic [CX_W-1:0] s1_cx_r;
  logic [CY_W-1:0] s1_cy_r;
  logic [T_W-1:0]  s1_t_r;
  logic            s1_pol_r;

  // S2 (output) registers
  logic            out_valid_r;
  logic [CX_W-1:0] out_cx_r;
  logic [CY_W-1:0] out_cy_r;
  logic [T_W-1:0]  out_t_r;
  logic            out_pol_r;

  // Filter history: the last event that passed into S2
  logic            last_valid_r;
  logic [CX_W-1:0] last_cx_r;
  logic [CY_W-1:0] last_cy_r;
  logic [T_W-1:0]  last_t_r;
  logic            last_pol_r;

  logic [CNT_W-1:0] pass_cnt_r;
  logic [CNT_W-1:0] drop_cnt_r;

  // Combinational control
  logic [CX_W-1:0] cx_in_s;
  logic [CY_W-1:0] cy_in_s;
  logic [T_W-1:0]  d_s;
  logic            match_s;
  logic            drop_s;
  logic            s1_go_s;
  logic            load_s2_s;
  logic            drop_ev_s;
  logic            in_ready_s;
  logic            accept_s;

  // Drop decision and handshake steering; delta wraps modulo 2^T_W
  always_comb begin
    cx_in_s    = CX_W'(bus.in_x >> SHIFT);
    cy_in_s    = CY_W'(bus.in_y >> SHIFT);
    d_s        = s1_t_r - last_t_r;
    match_s    = (s1_cx_r == last_cx_r) && (s1_cy_r == last_cy_r) && (s1_pol_r == last_pol_r);
    drop_s     = 1'b0;
    if (bus.flt_en && last_valid_r && match_s && (d_s < REFRACT_T)) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
    s1_go_s    = s1_valid_r && (drop_s || !out_valid_r || bus.out_ready);
    load_s2_s  = s1_go_s && !drop_s;
    drop_ev_s  = s1_go_s && drop_s;
    in_ready_s = !s1_valid_r || s1_go_s;
    accept_s   = bus.in_valid && in_ready_s;
  end

  // S1 capture: load on accept, empty when the event leaves without a replacement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_cx_r    <= '0;
      s1_cy_r    <= '0;
      s1_t_r     <= '0;
      s1_pol_r   <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_cx_r    <= cx_in_s;
      s1_cy_r    <= cy_in_s;
      s1_t_r     <= bus.in_t;
      s1_pol_r   <= bus.in_pol;
    end else if (s1_go_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2 output stage: load from S1 on pass, clear on drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_cx_r    <= '0;
      out_cy_r    <= '0;
      out_t_r     <= '0;
      out_pol_r   <= 1'b0;
    end else if (load_s2_s) begin
      out_valid_r <= 1'b1;
      out_cx_r    <= s1_cx_r;
      out_cy_r    <= s1_cy_r;
      out_t_r     <= s1_t_r;
      out_pol_r   <= s1_pol_r;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Filter history follows every passed event regardless of flt_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_valid_r <= 1'b0;
      last_cx_r    <= '0;
      last_cy_r    <= '0;
      last_t_r     <= '0;
      last_pol_r   <= 1'b0;
    end else if (load_s2_s) begin
      last_valid_r <= 1'b1;
      last_cx_r    <= s1_cx_r;
      last_cy_r    <= s1_cy_r;
      last_t_r     <= s1_t_r;
      last_pol_r   <= s1_pol_r;
    end else begin
      last_valid_r <= last_valid_r;
    end
  end

  // Saturating statistics, updated on the S1 leave decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_r <= '0;
      drop_cnt_r <= '0;
    end else if (load_s2_s) begin
      pass_cnt_r <= sat_inc(pass_cnt_r);
    end else if (drop_ev_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
    end else begin
      pass_cnt_r <= pass_cnt_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_cx    = out_cx_r;
  assign bus.out_cy    = out_cy_r;
  assign bus.out_t     = out_t_r;
  assign bus.out_pol   = out_pol_r;
  assign bus.pass_cnt  = pass_cnt_r;
  assign bus.drop_cnt  = drop_cnt_r;
endmodule
